// File: rtl/data_mem_bridge_pkg.sv
// Shared types and default sizing for the core-to-bus data memory bridge.
package data_mem_bridge_pkg;

  // Default sizing; the top-level parameters start from these values.
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Bridge control states. The top module mirrors these as plain 3-bit
  // constants so the state register stays a simple vector.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } bridge_state_t;

  // One posted store held in the write buffer.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/data_mem_bridge_if.sv
// Valid/ready memory bus between the bridge (master) and the memory system (slave).
// Writes are posted: only reads produce a response beat.
interface data_mem_bridge_if
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_write;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_rdata;

  modport master (
    output bus_req_valid,
    output bus_req_write,
    output bus_req_addr,
    output bus_req_wdata,
    input  bus_req_ready,
    input  bus_resp_valid,
    input  bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid,
    input  bus_req_write,
    input  bus_req_addr,
    input  bus_req_wdata,
    output bus_req_ready,
    output bus_resp_valid,
    output bus_resp_rdata
  );

endinterface

// File: rtl/data_mem_bridge_chk.sv
// Protocol checker for the core side of the bridge. Flags the illegal
// load+store strobe encoding (sticky flag plus assertion) and bounds the
// write-buffer occupancy. chk_en_i lets an environment mask the strobe
// assertion while deliberately exercising the illegal encoding.
module data_mem_bridge_chk
  import data_mem_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chk_en_i,
  input  logic                   should_read_mem,
  input  logic                   should_write_mem,
  input  logic [$clog2(DEPTH):0] wbuf_count,
  output logic                   illegal_seen_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

  logic illegal_seen_q;

  // Sticky record that both strobes were seen high at a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_seen_q <= 1'b0;
    end else if (should_read_mem && should_write_mem) begin
      illegal_seen_q <= 1'b1;
    end else begin
      illegal_seen_q <= illegal_seen_q;
    end
  end

  assign illegal_seen_o = illegal_seen_q;

  a_single_strobe: assert property (@(posedge clk) disable iff (!reset || !chk_en_i)
    !(should_read_mem && should_write_mem));

  a_count_range: assert property (@(posedge clk) disable iff (!reset)
    wbuf_count <= MAX_CNT);

endmodule

// File: rtl/data_mem_bridge_write_post_fifo.sv
// Posted-store buffer: DEPTH-entry synchronous FIFO with occupancy count.
// Push into a full FIFO and pop from an empty FIFO are ignored, so the count
// always stays within 0..DEPTH. DEPTH must be a power of two so the pointers
// wrap naturally.
module write_post_fifo
  import data_mem_bridge_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_q == FULL_CNT);
  assign empty_s   = (count_q == CNT_W'(0));
  assign do_push_s = push_i && !full_s;
  assign do_pop_s  = pop_i && !empty_s;

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_q;

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge between the core's single-cycle load/store strobes and a valid/ready
// memory bus. Stores are posted into a small write buffer and drained in the
// background; a load first drains the buffer (so it always observes earlier
// stores), then issues one read and holds the core on mem_busy until the data
// is back. mem_busy is combinational so the core can fold it into its PC hold
// in the same cycle the strobe is raised.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      data_addr,
  input  logic                   should_read_mem,
  input  logic                   should_write_mem,
  input  logic [DATA_W-1:0]      mem_write_data,
  output logic [DATA_W-1:0]      mem_read_data,
  output logic                   mem_busy,
  data_mem_bridge_if.master      bus,
  output logic [$clog2(DEPTH):0] wbuf_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_DRAIN   = DRAIN;
  localparam logic [2:0] S_RD_REQ  = RD_REQ;
  localparam logic [2:0] S_RD_WAIT = RD_WAIT;
  localparam logic [2:0] S_RD_DONE = RD_DONE;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [ENT_W-1:0]  head_s;
  logic              drain_phase_s;

  write_post_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({data_addr, mem_write_data}),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // The buffer drains whenever the bridge is not busy with a read.
  assign drain_phase_s = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign pop_s         = drain_phase_s && !empty_s && bus.bus_req_ready;

  // Next-state, read-address capture, load-data capture and store push decision.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rdata_d   = rdata_q;
    push_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A load wins over a simultaneous store; the store is dropped.
        if (should_read_mem) begin
          if (!empty_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d   = S_RD_REQ;
            rd_addr_d = data_addr;
          end
        end else if (should_write_mem && !full_s) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      S_DRAIN: begin
        // Leave once the last posted store has been handed to the bus.
        if (empty_s || (pop_s && (count_s == CNT_W'(1)))) begin
          state_d   = S_RD_REQ;
          rd_addr_d = data_addr;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_RD_REQ: begin
        if (bus.bus_req_ready) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (bus.bus_resp_valid) begin
          rdata_d = bus.bus_resp_rdata;
          state_d = S_RD_DONE;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and captured read address/data; reset abandons any bus request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rdata_q   <= rdata_d;
    end
  end

  // Bus request: buffer head while draining, the captured read address in RD_REQ.
  always_comb begin
    bus.bus_req_valid = 1'b0;
    bus.bus_req_write = 1'b0;
    bus.bus_req_addr  = '0;
    bus.bus_req_wdata = '0;
    if (drain_phase_s && !empty_s) begin
      bus.bus_req_valid = 1'b1;
      bus.bus_req_write = 1'b1;
      bus.bus_req_addr  = head_s[ENT_W-1:DATA_W];
      bus.bus_req_wdata = head_s[DATA_W-1:0];
    end else if (state_q == S_RD_REQ) begin
      bus.bus_req_valid = 1'b1;
      bus.bus_req_write = 1'b0;
      bus.bus_req_addr  = rd_addr_q;
      bus.bus_req_wdata = '0;
    end else begin
      bus.bus_req_valid = 1'b0;
      bus.bus_req_write = 1'b0;
    end
  end

  // Core stall: loads stall until RD_DONE; stores stall only on a full buffer.
  always_comb begin
    mem_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (should_read_mem) begin
          mem_busy = 1'b1;
        end else if (should_write_mem && full_s) begin
          mem_busy = 1'b1;
        end else begin
          mem_busy = 1'b0;
        end
      end
      S_DRAIN:   mem_busy = 1'b1;
      S_RD_REQ:  mem_busy = 1'b1;
      S_RD_WAIT: mem_busy = 1'b1;
      S_RD_DONE: mem_busy = 1'b0;
      default:   mem_busy = 1'b0;
    endcase
  end

  assign mem_read_data = rdata_q;
  assign wbuf_count    = count_s;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: emulates the core strobes and a
// memory bus, with a scoreboard of expected bus requests in issue order.
module tb_data_mem_bridge;
  import data_mem_bridge_pkg::*;

  typedef struct packed {
    logic        wr;
    wbuf_entry_t ent;
  } bus_txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr;
  logic        should_read_mem;
  logic        should_write_mem;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic [2:0]  wbuf_count;
  logic        chk_en;
  logic        illegal_seen;

  logic        resp_en;
  logic        rd_pending;
  logic [31:0] resp_data;

  bus_txn_t    exp_q[$];
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          bus_seen   = 0;
  int          bus_pushed = 0;

  data_mem_bridge_if bus_if ();

  always #5 clk = ~clk;

  data_mem_bridge #(
    .DEPTH  (4),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_addr        (data_addr),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_busy         (mem_busy),
    .bus              (bus_if),
    .wbuf_count       (wbuf_count)
  );

  data_mem_bridge_chk #(
    .DEPTH (4)
  ) u_chk (
    .clk              (clk),
    .reset            (reset),
    .chk_en_i         (chk_en),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .wbuf_count       (wbuf_count),
    .illegal_seen_o   (illegal_seen)
  );

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus monitor: every accepted request is compared against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (reset && bus_if.bus_req_valid && bus_if.bus_req_ready) begin
      bus_txn_t t;
      bus_seen++;
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check_eq("bus_txn", {31'd0, bus_if.bus_req_write, bus_if.bus_req_addr, bus_if.bus_req_wdata},
                 {31'd0, t});
      end
      if (resp_en && !bus_if.bus_req_write) rd_pending = 1'b1;
    end
  end

  // Memory responder: one read beat the cycle after a read request is accepted.
  initial forever begin
    @(posedge clk);
    #1;
    if (resp_en) begin
      bus_if.bus_resp_valid = rd_pending;
      bus_if.bus_resp_rdata = rd_pending ? resp_data : 32'h0;
      rd_pending            = 1'b0;
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus_txn_t t;
    should_write_mem = 1'b1;
    data_addr        = a;
    mem_write_data   = d;
    #1;
    check_eq("store_no_stall", 96'(mem_busy), 96'(1'b0));
    t = {1'b1, a, d};
    exp_q.push_back(t);
    bus_pushed++;
    @(posedge clk);
    #1;
    should_write_mem = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] rd,
                         input int exp_busy);
    bus_txn_t t;
    int       busy_n = 0;
    t = {1'b0, a, 32'h0};
    exp_q.push_back(t);
    bus_pushed++;
    resp_data       = rd;
    should_read_mem = 1'b1;
    data_addr       = a;
    #1;
    while (mem_busy && busy_n < 40) begin
      busy_n++;
      @(posedge clk);
      #2;
    end
    check_eq({tag, "_busy_cycles"}, 96'(busy_n), 96'(exp_busy));
    check_eq({tag, "_rdata"}, 96'(mem_read_data), 96'(rd));
    @(posedge clk);
    #1;
    should_read_mem  = 1'b0;
    should_write_mem = 1'b0;
    #1;
    check_eq({tag, "_rdata_hold"}, 96'(mem_read_data), 96'(rd));
    check_eq({tag, "_idle_busy"}, 96'(mem_busy), 96'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset                 = 1'b0;
    data_addr             = 32'h0;
    should_read_mem       = 1'b0;
    should_write_mem      = 1'b0;
    mem_write_data        = 32'h0;
    chk_en                = 1'b1;
    resp_en               = 1'b1;
    rd_pending            = 1'b0;
    resp_data             = 32'h0;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = 32'h0;

    // Reset state
    #12;
    check_eq("rst_valid", 96'(bus_if.bus_req_valid), 96'(1'b0));
    check_eq("rst_write", 96'(bus_if.bus_req_write), 96'(1'b0));
    check_eq("rst_addr", 96'(bus_if.bus_req_addr), 96'(32'h0));
    check_eq("rst_wdata", 96'(bus_if.bus_req_wdata), 96'(32'h0));
    check_eq("rst_rdata", 96'(mem_read_data), 96'(32'h0));
    check_eq("rst_count", 96'(wbuf_count), 96'(3'd0));
    check_eq("rst_busy", 96'(mem_busy), 96'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single posted store with a ready bus
    bus_if.bus_req_ready = 1'b1;
    @(posedge clk);
    #1;
    do_store(32'h100, 32'hDEAD_BEEF);
    #1;
    check_eq("st1_valid", 96'(bus_if.bus_req_valid), 96'(1'b1));
    check_eq("st1_write", 96'(bus_if.bus_req_write), 96'(1'b1));
    check_eq("st1_addr", 96'(bus_if.bus_req_addr), 96'(32'h100));
    check_eq("st1_wdata", 96'(bus_if.bus_req_wdata), 96'(32'hDEAD_BEEF));
    check_eq("st1_count1", 96'(wbuf_count), 96'(3'd1));
    @(posedge clk);
    #2;
    check_eq("st1_count0", 96'(wbuf_count), 96'(3'd0));
    check_eq("st1_idle_valid", 96'(bus_if.bus_req_valid), 96'(1'b0));

    // Five back-to-back stores against a stalled bus: fill, stall, then release
    bus_if.bus_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h300 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    end
    #1;
    check_eq("full_count", 96'(wbuf_count), 96'(3'd4));
    should_write_mem = 1'b1;
    data_addr        = 32'h310;
    mem_write_data   = 32'hC0DE_0004;
    #1;
    check_eq("full_stall", 96'(mem_busy), 96'(1'b1));
    bus_if.bus_req_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("full_pop_no_push", 96'(wbuf_count), 96'(3'd3));
    check_eq("full_release", 96'(mem_busy), 96'(1'b0));
    begin
      bus_txn_t t5;
      t5 = {1'b1, 32'h310, 32'hC0DE_0004};
      exp_q.push_back(t5);
      bus_pushed++;
    end
    @(posedge clk);
    #1;
    should_write_mem = 1'b0;
    check_eq("fifth_push_pop", 96'(wbuf_count), 96'(3'd3));
    n = 0;
    while (wbuf_count != 3'd0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_count0", 96'(wbuf_count), 96'(3'd0));

    // Load with empty buffer and zero-wait bus
    do_load("ld_empty", 32'h200, 32'h1234_5678, 3);

    // Two posted stores then a load: read must follow both writes
    bus_if.bus_req_ready = 1'b0;
    do_store(32'h10, 32'h1111_0010);
    do_store(32'h14, 32'h2222_0014);
    bus_if.bus_req_ready = 1'b1;
    do_load("ld_after_st", 32'h10, 32'hA5A5_0010, 4);

    // Reset while waiting for read data; a late response must be ignored
    resp_en = 1'b0;
    begin
      bus_txn_t tr;
      tr = {1'b0, 32'h240, 32'h0};
      exp_q.push_back(tr);
      bus_pushed++;
    end
    should_read_mem = 1'b1;
    data_addr       = 32'h240;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("rdwait_busy", 96'(mem_busy), 96'(1'b1));
    check_eq("rdwait_valid", 96'(bus_if.bus_req_valid), 96'(1'b0));
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 96'(bus_if.bus_req_valid), 96'(1'b0));
    check_eq("midrst_rdata", 96'(mem_read_data), 96'(32'h0));
    check_eq("midrst_count", 96'(wbuf_count), 96'(3'd0));
    should_read_mem = 1'b0;
    #1;
    check_eq("midrst_idle", 96'(mem_busy), 96'(1'b0));
    @(posedge clk);
    #1;
    reset                 = 1'b1;
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_resp_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_resp_rdata = 32'h0;
    check_eq("late_resp_ignored", 96'(mem_read_data), 96'(32'h0));
    check_eq("late_resp_idle", 96'(mem_busy), 96'(1'b0));
    resp_en = 1'b1;

    // Both strobes together: load serviced, store dropped, checker flags it
    chk_en           = 1'b0;
    should_write_mem = 1'b1;
    mem_write_data   = 32'h7777_7777;
    do_load("ld_both", 32'h280, 32'h0F0F_1234, 3);
    check_eq("both_no_push", 96'(wbuf_count), 96'(3'd0));
    check_eq("both_flagged", 96'(illegal_seen), 96'(1'b1));
    chk_en = 1'b1;

    // Scoreboard closure
    repeat (5) @(posedge clk);
    #1;
    check_eq("sb_drained", 96'(exp_q.size()), 96'(0));
    check_eq("bus_txn_count", 96'(bus_seen), 96'(bus_pushed));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
